// File: rtl/key_pkg.sv
// Shared state encoding and 50 MHz default timing for the push-button decoder.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        PRESSED = 2'd2,
        FILT_UP = 2'd3
    } key_state_e;

    localparam int unsigned CNT_MAX_DEF  = 32'd1_000_000;
    localparam int unsigned LONG_MAX_DEF = 32'd50_000_000;
    localparam int unsigned CNT_W_DEF    = 32'd26;

    // True while the debounced key counts as held down
    function automatic logic is_down(input key_state_e st);
        return (st == PRESSED) || (st == FILT_UP);
    endfunction

endpackage

// File: rtl/key_press_decoder_if.sv
// Key pin and event/level lines between the board-side driver and the decoder.
interface key_press_decoder_if;

    logic key_in;
    logic key_flag;
    logic release_flag;
    logic long_flag;
    logic key_level;

    modport master (
        output key_in,
        input  key_flag,
        input  release_flag,
        input  long_flag,
        input  key_level
    );

    modport slave (
        input  key_in,
        output key_flag,
        output release_flag,
        output long_flag,
        output key_level
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_r <= RST_VAL;
            q_r    <= RST_VAL;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/key_press_decoder.sv
// Debounces an active-low push-button and emits press, release and long-press pulses
// plus a clean pressed level, all registered on sys_clk.
module key_press_decoder
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX = LONG_MAX_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    key_press_decoder_if.slave kif
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(CNT_MAX - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_MAX - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic             key_sync_s;
    key_state_e       state_r;
    key_state_e       state_nxt_s;
    logic [CNT_W-1:0] deb_cnt_r;
    logic [CNT_W-1:0] deb_cnt_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_cnt_nxt_s;
    logic             hold_at_max_s;
    logic             hold_max_d_r;
    logic             key_flag_r;
    logic             release_flag_r;
    logic             long_flag_r;
    logic             key_level_r;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (kif.key_in),
        .q         (key_sync_s)
    );

    // Debounce FSM next state and filter counter; any disagreeing sample restarts the window
    always_comb begin
        state_nxt_s   = state_r;
        deb_cnt_nxt_s = CNT_ZERO;
        case (state_r)
            IDLE: begin
                if (!key_sync_s) begin
                    state_nxt_s = FILT_DN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILT_DN: begin
                if (key_sync_s) begin
                    state_nxt_s = IDLE;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = PRESSED;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (key_sync_s) begin
                    state_nxt_s = FILT_UP;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            FILT_UP: begin
                if (!key_sync_s) begin
                    state_nxt_s = PRESSED;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign hold_at_max_s = (hold_cnt_r == HOLD_LAST);

    // Hold timer keeps running through a rejected up-bounce and saturates
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        if (!is_down(state_r)) begin
            hold_cnt_nxt_s = CNT_ZERO;
        end else if (!hold_at_max_s) begin
            hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r        <= IDLE;
            deb_cnt_r      <= CNT_ZERO;
            hold_cnt_r     <= CNT_ZERO;
            hold_max_d_r   <= 1'b0;
            key_flag_r     <= 1'b0;
            release_flag_r <= 1'b0;
            long_flag_r    <= 1'b0;
            key_level_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            deb_cnt_r      <= deb_cnt_nxt_s;
            hold_cnt_r     <= hold_cnt_nxt_s;
            hold_max_d_r   <= hold_at_max_s;
            key_flag_r     <= (state_r == FILT_DN) && (state_nxt_s == PRESSED);
            release_flag_r <= (state_r == FILT_UP) && (state_nxt_s == IDLE);
            // Rising edge of saturation gives exactly one pulse per press
            long_flag_r    <= hold_at_max_s && !hold_max_d_r;
            key_level_r    <= is_down(state_nxt_s);
        end
    end

    assign kif.key_flag     = key_flag_r;
    assign kif.release_flag = release_flag_r;
    assign kif.long_flag    = long_flag_r;
    assign kif.key_level    = key_level_r;

endmodule

// File: tb/tb_key_press_decoder.sv
// Bench for key_press_decoder: segment table, exact-timing sequences and a
// randomized run against a run-length/timestamp reference model.
module tb_key_press_decoder;

    localparam int CNT_MAX  = 10;
    localparam int LONG_MAX = 50;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    key_press_decoder_if kif();

    key_press_decoder #(
        .CNT_MAX  (CNT_MAX),
        .LONG_MAX (LONG_MAX),
        .CNT_W    (26)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kif       (kif)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic key;
        int   len;
        int   kf;
        int   rf;
        int   lf;
        logic lvl;
    } seg_t;

    seg_t tbl [11];

    logic kf_at  [0:129];
    logic rf_at  [0:129];
    logic lf_at  [0:129];
    logic lvl_at [0:129];

    // reference model state
    logic m_s1, m_s2, m_lvl;
    int   m_run, m_edge, m_press, m_rel;
    logic e_kf, e_rf, e_lf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        kif.key_in = 1'b1;
        repeat (3) tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic model_init();
        m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0;
        m_run = 0; m_edge = 0; m_press = -1000; m_rel = -1000;
    endtask

    // One clock edge: level flips after CNT_MAX+1 consecutive disagreeing samples;
    // long press fires LONG_MAX edges after the press unless released too early.
    task automatic model_edge(input logic k);
        m_edge++;
        e_kf = 1'b0;
        e_rf = 1'b0;
        e_lf = (m_press >= 0) && (m_edge == m_press + LONG_MAX) &&
               !((m_rel > m_press) && (m_rel < m_press + LONG_MAX - 1));
        if ((!m_s2) != m_lvl) m_run++;
        else m_run = 0;
        if (m_run == CNT_MAX + 1) begin
            m_lvl = !m_lvl;
            m_run = 0;
            if (m_lvl) begin e_kf = 1'b1; m_press = m_edge; end
            else begin e_rf = 1'b1; m_rel = m_edge; end
        end
        m_s2 = m_s1;
        m_s1 = k;
    endtask

    task automatic run_edges(input logic k, input int n);
        kif.key_in = k;
        for (int e = 1; e <= n; e++) begin
            tick();
            kf_at[e]  = kif.key_flag;
            rf_at[e]  = kif.release_flag;
            lf_at[e]  = kif.long_flag;
            lvl_at[e] = kif.key_level;
        end
    endtask

    function automatic int count_ones(input int which, input int lo, input int hi);
        int s = 0;
        for (int e = lo; e <= hi; e++) begin
            if (which == 0) s += int'(kf_at[e]);
            else if (which == 1) s += int'(rf_at[e]);
            else s += int'(lf_at[e]);
        end
        return s;
    endfunction

    initial begin
        int kf_c, rf_c, lf_c, seg_left;
        logic cur;

        tbl[0]  = '{1'b1, 20, 0, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 30, 1, 0, 0, 1'b1};
        tbl[2]  = '{1'b1, 20, 0, 1, 0, 1'b0};
        tbl[3]  = '{1'b0,  5, 0, 0, 0, 1'b0};
        tbl[4]  = '{1'b1,  3, 0, 0, 0, 1'b0};
        tbl[5]  = '{1'b0, 20, 1, 0, 0, 1'b1};
        tbl[6]  = '{1'b1, 20, 0, 1, 0, 1'b0};
        tbl[7]  = '{1'b0, 80, 1, 0, 1, 1'b1};
        tbl[8]  = '{1'b1, 20, 0, 1, 0, 1'b0};
        tbl[9]  = '{1'b0, 11, 0, 0, 0, 1'b0};
        tbl[10] = '{1'b1, 30, 1, 1, 0, 1'b0};

        kif.key_in = 1'b1;
        sys_rst_n  = 1'b0;
        repeat (2) tick();
        check("rst_key_flag", int'(kif.key_flag), 0);
        check("rst_release_flag", int'(kif.release_flag), 0);
        check("rst_long_flag", int'(kif.long_flag), 0);
        check("rst_key_level", int'(kif.key_level), 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            kf_c = 0; rf_c = 0; lf_c = 0;
            kif.key_in = tbl[i].key;
            for (int c = 0; c < tbl[i].len; c++) begin
                tick();
                kf_c += int'(kif.key_flag);
                rf_c += int'(kif.release_flag);
                lf_c += int'(kif.long_flag);
            end
            check($sformatf("seg%0d_key_flags", i), kf_c, tbl[i].kf);
            check($sformatf("seg%0d_release_flags", i), rf_c, tbl[i].rf);
            check($sformatf("seg%0d_long_flags", i), lf_c, tbl[i].lf);
            check($sformatf("seg%0d_level", i), int'(kif.key_level), int'(tbl[i].lvl));
        end

        // clean press held long: exact key_flag and long_flag edges
        run_edges(1'b0, 120);
        check("press_kf_e12", int'(kf_at[12]), 0);
        check("press_kf_e13", int'(kf_at[13]), 1);
        check("press_kf_e14", int'(kf_at[14]), 0);
        check("press_lvl_e12", int'(lvl_at[12]), 0);
        check("press_lvl_e13", int'(lvl_at[13]), 1);
        check("press_kf_total", count_ones(0, 1, 120), 1);
        check("long_e62", int'(lf_at[62]), 0);
        check("long_e63", int'(lf_at[63]), 1);
        check("long_total", count_ones(2, 1, 120), 1);

        // release timing
        run_edges(1'b1, 20);
        check("rel_rf_e12", int'(rf_at[12]), 0);
        check("rel_rf_e13", int'(rf_at[13]), 1);
        check("rel_lvl_e13", int'(lvl_at[13]), 0);
        check("rel_kf_total", count_ones(0, 1, 20), 0);

        // reset mid-press, then key still held at reset release
        run_edges(1'b0, 20);
        check("pre_rst_level", int'(kif.key_level), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_key_level", int'(kif.key_level), 0);
        check("midrst_flags", int'(kif.key_flag | kif.release_flag | kif.long_flag), 0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        run_edges(1'b0, 16);
        check("postrst_kf_early", count_ones(0, 1, 12), 0);
        check("postrst_kf_e13", int'(kf_at[13]), 1);

        // randomized run against the reference model
        do_reset();
        model_init();
        seg_left = 0;
        cur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (seg_left == 0) begin
                cur = !cur;
                if ($urandom_range(0, 2) == 0) seg_left = int'($urandom_range(1, 14));
                else seg_left = int'($urandom_range(15, 90));
            end
            seg_left--;
            kif.key_in = cur;
            tick();
            model_edge(cur);
            check("rnd_key_flag", int'(kif.key_flag), int'(e_kf));
            check("rnd_release_flag", int'(kif.release_flag), int'(e_rf));
            check("rnd_long_flag", int'(kif.long_flag), int'(e_lf));
            check("rnd_key_level", int'(kif.key_level), int'(m_lvl));
            check("rnd_exclusive", int'(kif.key_flag & kif.release_flag), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
